// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and optional initialiser in front of
// a single-write-port memory with combinational read. It serialises client reads
// and writes to one per cycle and returns registered one-cycle responses.
//
// Build option: define MEM_ARB_INIT_SWEEP_EN to write INIT_VALUE to every entry
// after reset, before any traffic is accepted. When it is undefined, traffic is
// accepted from the first cycle after reset deasserts.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-low reset
//   io_req_valid/write per-port request valid and write flag (bit p = port p)
//   io_req_addr/wdata  per-port address and write data, port p at [p*W +: W]
//   io_req_ready       one-hot grant, combinational
//   io_resp_valid      per-port response pulse, one cycle after accept
//   io_resp_data       shared response data: read data, or the written data
//   io_init_done       high while traffic can be accepted
//   io_mem_*           memory write port, read address, and read data
module mem_arbiter #(
    parameter int unsigned       ADDR_W     = 2,
    parameter int unsigned       DATA_W     = 2,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            io_req_valid,
    input  logic [1:0]            io_req_write,
    input  logic [2*ADDR_W-1:0]   io_req_addr,
    input  logic [2*DATA_W-1:0]   io_req_wdata,
    output logic [1:0]            io_req_ready,
    output logic [1:0]            io_resp_valid,
    output logic [DATA_W-1:0]     io_resp_data,
    output logic                  io_init_done,
    output logic                  io_mem_wrEna,
    output logic [ADDR_W-1:0]     io_mem_wrAddr,
    output logic [DATA_W-1:0]     io_mem_wrData,
    output logic [ADDR_W-1:0]     io_mem_rdAddr,
    input  logic [DATA_W-1:0]     io_mem_rdData
);

    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;

    assign addr0  = io_req_addr[0 +: ADDR_W];
    assign addr1  = io_req_addr[ADDR_W +: ADDR_W];
    assign wdata0 = io_req_wdata[0 +: DATA_W];
    assign wdata1 = io_req_wdata[DATA_W +: DATA_W];

    // Priority pointer: 0 favours port 0, 1 favours port 1 when both are valid.
    logic              ptr_q, ptr_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;

    logic              in_run;
    logic [1:0]        grant;
    logic              win;
    logic              win_write;
    logic              accept;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

`ifdef MEM_ARB_INIT_SWEEP_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    assign in_run = (state_q == ST_RUN);
`else
    assign in_run = 1'b1;
`endif

    // Grant, memory drive, pointer and response next-state.
    always_comb begin
        grant         = 2'b00;
        if (reset && in_run) begin
            case (io_req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end

        win           = grant[1];
        accept        = |grant;
        win_write     = io_req_write[win];
        win_addr      = win ? addr1 : addr0;
        win_wdata     = win ? wdata1 : wdata0;

        io_req_ready  = grant;
        io_mem_wrEna  = accept & win_write;
        io_mem_wrAddr = win_addr;
        io_mem_wrData = (accept & win_write) ? win_wdata : INIT_VALUE;
        io_mem_rdAddr = (accept & ~win_write) ? win_addr : addr0;

        ptr_d         = accept ? ~win : ptr_q;
        resp_valid_d  = grant;
        resp_data_d   = resp_data_q;
        if (accept) begin
            resp_data_d = win_write ? win_wdata : io_mem_rdData;
        end

`ifdef MEM_ARB_INIT_SWEEP_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            // Sweep one entry per cycle; leave after the last address is written.
            cnt_d         = cnt_q + ADDR_W'(1);
            io_mem_wrEna  = reset;
            io_mem_wrAddr = cnt_q;
            io_mem_wrData = INIT_VALUE;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
`endif
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q        <= 1'b0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
`ifdef MEM_ARB_INIT_SWEEP_EN
            state_q      <= ST_INIT;
            cnt_q        <= '0;
`endif
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
`ifdef MEM_ARB_INIT_SWEEP_EN
            state_q      <= state_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign io_resp_valid = resp_valid_q;
    assign io_resp_data  = resp_data_q;
    // Gated by reset so it reads 0 while reset is held, in either build.
    assign io_init_done  = reset & in_run;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 4x2 memory attached.
module tb_mem_arbiter;

    logic       clock;
    logic       reset;
    logic [1:0] io_req_valid;
    logic [1:0] io_req_write;
    logic [3:0] io_req_addr;
    logic [3:0] io_req_wdata;
    logic [1:0] io_req_ready;
    logic [1:0] io_resp_valid;
    logic [1:0] io_resp_data;
    logic       io_init_done;
    logic       io_mem_wrEna;
    logic [1:0] io_mem_wrAddr;
    logic [1:0] io_mem_wrData;
    logic [1:0] io_mem_rdAddr;
    logic [1:0] io_mem_rdData;

    logic [1:0] mem [4];
    logic [1:0] exp_mem [4];

    int vectors;
    int miscompares;

    mem_arbiter dut (
        .clock         (clock),
        .reset         (reset),
        .io_req_valid  (io_req_valid),
        .io_req_write  (io_req_write),
        .io_req_addr   (io_req_addr),
        .io_req_wdata  (io_req_wdata),
        .io_req_ready  (io_req_ready),
        .io_resp_valid (io_resp_valid),
        .io_resp_data  (io_resp_data),
        .io_init_done  (io_init_done),
        .io_mem_wrEna  (io_mem_wrEna),
        .io_mem_wrAddr (io_mem_wrAddr),
        .io_mem_wrData (io_mem_wrData),
        .io_mem_rdAddr (io_mem_rdAddr),
        .io_mem_rdData (io_mem_rdData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (io_mem_wrEna) mem[io_mem_wrAddr] <= io_mem_wrData;
    end
    assign io_mem_rdData = mem[io_mem_rdAddr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [1:0] w,
                           input logic [1:0] a0, input logic [1:0] a1,
                           input logic [1:0] d0, input logic [1:0] d1);
        io_req_valid = v;
        io_req_write = w;
        io_req_addr  = {a1, a0};
        io_req_wdata = {d1, d0};
    endtask

    task automatic do_reset();
        set_req(2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
`ifdef MEM_ARB_INIT_SWEEP_EN
        repeat (4) tick();
        for (int i = 0; i < 4; i++) exp_mem[i] = 2'd0;
`endif
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            set_req(2'b11, 2'b11, 2'd1, 2'd2, 2'd3, 2'd1);
            #1;
            vectors++; if (io_req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready got %b want 00", io_req_ready); end
            vectors++; if (io_mem_wrEna !== 1'b0) begin miscompares++; $display("FAIL reset_wrena got %b want 0", io_mem_wrEna); end
            tick();
            vectors++; if (io_resp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_resp_valid got %b want 00", io_resp_valid); end
            vectors++; if (io_resp_data !== 2'd0) begin miscompares++; $display("FAIL reset_resp_data got %0d want 0", io_resp_data); end
            vectors++; if (io_init_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done got %b want 0", io_init_done); end
        end
    endtask

`ifdef MEM_ARB_INIT_SWEEP_EN
    task automatic test_init_sweep();
        reset = 1'b1;
        set_req(2'b11, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (io_mem_wrEna !== 1'b1) begin miscompares++; $display("FAIL sweep_wrena[%0d] got %b want 1", i, io_mem_wrEna); end
            vectors++; if (io_mem_wrAddr !== 2'(i)) begin miscompares++; $display("FAIL sweep_addr[%0d] got %0d want %0d", i, io_mem_wrAddr, i); end
            vectors++; if (io_mem_wrData !== 2'd0) begin miscompares++; $display("FAIL sweep_data[%0d] got %0d want 0", i, io_mem_wrData); end
            vectors++; if (io_req_ready !== 2'b00) begin miscompares++; $display("FAIL sweep_ready[%0d] got %b want 00", i, io_req_ready); end
            vectors++; if (io_init_done !== 1'b0) begin miscompares++; $display("FAIL sweep_done[%0d] got %b want 0", i, io_init_done); end
            tick();
        end
        for (int i = 0; i < 4; i++) exp_mem[i] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            set_req(2'b01, 2'b00, 2'(i), 2'd0, 2'd0, 2'd0);
            #1;
            vectors++; if (io_init_done !== 1'b1) begin miscompares++; $display("FAIL sweep_done_run[%0d] got %b want 1", i, io_init_done); end
            vectors++; if (io_req_ready !== 2'b01) begin miscompares++; $display("FAIL sweep_rd_ready[%0d] got %b want 01", i, io_req_ready); end
            tick();
            vectors++; if (io_resp_data !== 2'd0) begin miscompares++; $display("FAIL sweep_rd_data[%0d] got %0d want 0", i, io_resp_data); end
        end
        set_req(2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
    endtask
`else
    task automatic test_first_cycle();
        reset = 1'b1;
        set_req(2'b01, 2'b01, 2'd1, 2'd0, 2'd2, 2'd0);
        #1;
        vectors++; if (io_init_done !== 1'b1) begin miscompares++; $display("FAIL first_init_done got %b want 1", io_init_done); end
        vectors++; if (io_req_ready !== 2'b01) begin miscompares++; $display("FAIL first_ready got %b want 01", io_req_ready); end
        vectors++; if (io_mem_wrEna !== 1'b1) begin miscompares++; $display("FAIL first_wrena got %b want 1", io_mem_wrEna); end
        vectors++; if (io_mem_wrAddr !== 2'd1) begin miscompares++; $display("FAIL first_wraddr got %0d want 1", io_mem_wrAddr); end
        vectors++; if (io_mem_wrData !== 2'd2) begin miscompares++; $display("FAIL first_wrdata got %0d want 2", io_mem_wrData); end
        tick();
        exp_mem[1] = 2'd2;
        vectors++; if (io_resp_valid !== 2'b01) begin miscompares++; $display("FAIL first_resp_valid got %b want 01", io_resp_valid); end
        vectors++; if (io_resp_data !== 2'd2) begin miscompares++; $display("FAIL first_resp_data got %0d want 2", io_resp_data); end
        set_req(2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
    endtask
`endif

    task automatic test_write_read();
        do_reset();
        // Port 0 writes addr 2 = 3.
        set_req(2'b01, 2'b01, 2'd2, 2'd0, 2'd3, 2'd0);
        #1;
        vectors++; if (io_req_ready !== 2'b01) begin miscompares++; $display("FAIL wr0_ready got %b want 01", io_req_ready); end
        vectors++; if ({io_mem_wrEna, io_mem_wrAddr, io_mem_wrData} !== {1'b1, 2'd2, 2'd3}) begin miscompares++; $display("FAIL wr0_mem got %b/%0d/%0d want 1/2/3", io_mem_wrEna, io_mem_wrAddr, io_mem_wrData); end
        tick();
        exp_mem[2] = 2'd3;
        vectors++; if (io_resp_valid !== 2'b01) begin miscompares++; $display("FAIL wr0_resp_valid got %b want 01", io_resp_valid); end
        vectors++; if (io_resp_data !== 2'd3) begin miscompares++; $display("FAIL wr0_resp_data got %0d want 3", io_resp_data); end
        // Port 1 reads addr 2 on the very next cycle.
        set_req(2'b10, 2'b00, 2'd0, 2'd2, 2'd0, 2'd0);
        #1;
        vectors++; if (io_req_ready !== 2'b10) begin miscompares++; $display("FAIL rd1_ready got %b want 10", io_req_ready); end
        vectors++; if (io_mem_rdAddr !== 2'd2) begin miscompares++; $display("FAIL rd1_rdaddr got %0d want 2", io_mem_rdAddr); end
        vectors++; if (io_mem_wrEna !== 1'b0) begin miscompares++; $display("FAIL rd1_wrena got %b want 0", io_mem_wrEna); end
        tick();
        vectors++; if (io_resp_valid !== 2'b10) begin miscompares++; $display("FAIL rd1_resp_valid got %b want 10", io_resp_valid); end
        vectors++; if (io_resp_data !== 2'd3) begin miscompares++; $display("FAIL rd1_resp_data got %0d want 3", io_resp_data); end
        // Port 1 writes addr 1 = 1, then port 0 reads it back.
        set_req(2'b10, 2'b10, 2'd0, 2'd1, 2'd0, 2'd1);
        #1;
        vectors++; if ({io_req_ready, io_mem_wrEna, io_mem_wrAddr, io_mem_wrData} !== {2'b10, 1'b1, 2'd1, 2'd1}) begin miscompares++; $display("FAIL wr1_mem got %b/%b/%0d/%0d want 10/1/1/1", io_req_ready, io_mem_wrEna, io_mem_wrAddr, io_mem_wrData); end
        tick();
        exp_mem[1] = 2'd1;
        set_req(2'b01, 2'b00, 2'd1, 2'd0, 2'd0, 2'd0);
        #1;
        vectors++; if (io_req_ready !== 2'b01) begin miscompares++; $display("FAIL rd0_ready got %b want 01", io_req_ready); end
        tick();
        vectors++; if ({io_resp_valid, io_resp_data} !== {2'b01, 2'd1}) begin miscompares++; $display("FAIL rd0_resp got %b/%0d want 01/1", io_resp_valid, io_resp_data); end
        set_req(2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
        #1;
        vectors++; if (io_req_ready !== 2'b00) begin miscompares++; $display("FAIL idle_ready got %b want 00", io_req_ready); end
        vectors++; if (io_mem_wrEna !== 1'b0) begin miscompares++; $display("FAIL idle_wrena got %b want 0", io_mem_wrEna); end
        tick();
        vectors++; if (io_resp_valid !== 2'b00) begin miscompares++; $display("FAIL idle_resp_valid got %b want 00", io_resp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] er;
        logic [1:0] ed;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_req(2'b11, 2'b00, 2'd2, 2'd1, 2'd0, 2'd0);
            er = (k % 2 == 0) ? 2'b01 : 2'b10;
            ed = (k % 2 == 0) ? exp_mem[2] : exp_mem[1];
            #1;
            vectors++; if (io_req_ready !== er) begin miscompares++; $display("FAIL alt_ready[%0d] got %b want %b", k, io_req_ready, er); end
            tick();
            vectors++; if (io_resp_valid !== er) begin miscompares++; $display("FAIL alt_resp_valid[%0d] got %b want %b", k, io_resp_valid, er); end
            vectors++; if (io_resp_data !== ed) begin miscompares++; $display("FAIL alt_resp_data[%0d] got %0d want %0d", k, io_resp_data, ed); end
        end
        set_req(2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
    endtask

    task automatic test_lone_and_drop();
        do_reset();
        // Port 1 alone while the pointer favours port 0.
        set_req(2'b10, 2'b00, 2'd0, 2'd2, 2'd0, 2'd0);
        #1;
        vectors++; if (io_req_ready !== 2'b10) begin miscompares++; $display("FAIL lone1_ready got %b want 10", io_req_ready); end
        tick();
        vectors++; if ({io_resp_valid, io_resp_data} !== {2'b10, exp_mem[2]}) begin miscompares++; $display("FAIL lone1_resp got %b/%0d want 10/%0d", io_resp_valid, io_resp_data, exp_mem[2]); end
        set_req(2'b11, 2'b00, 2'd1, 2'd2, 2'd0, 2'd0);
        #1;
        vectors++; if (io_req_ready !== 2'b01) begin miscompares++; $display("FAIL contest_ready got %b want 01", io_req_ready); end
        tick();
        // Valid dropped for a cycle: no access, pointer still favours port 1.
        set_req(2'b00, 2'b11, 2'd3, 2'd3, 2'd1, 2'd1);
        #1;
        vectors++; if ({io_req_ready, io_mem_wrEna} !== 3'b000) begin miscompares++; $display("FAIL drop_idle got %b/%b want 00/0", io_req_ready, io_mem_wrEna); end
        tick();
        set_req(2'b11, 2'b00, 2'd1, 2'd2, 2'd0, 2'd0);
        #1;
        vectors++; if (io_req_ready !== 2'b10) begin miscompares++; $display("FAIL drop_contest_ready got %b want 10", io_req_ready); end
        tick();
        set_req(2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(2'b01, 2'b00, 2'd2, 2'd0, 2'd0, 2'd0);
        #1;
        vectors++; if (io_req_ready !== 2'b01) begin miscompares++; $display("FAIL mid_pre_ready got %b want 01", io_req_ready); end
        tick();
        // Reset lands while both ports request; nothing may be accepted.
        reset = 1'b0;
        set_req(2'b11, 2'b00, 2'd2, 2'd1, 2'd0, 2'd0);
        #1;
        vectors++; if (io_req_ready !== 2'b00) begin miscompares++; $display("FAIL mid_ready got %b want 00", io_req_ready); end
        tick();
        vectors++; if (io_resp_valid !== 2'b00) begin miscompares++; $display("FAIL mid_resp_valid got %b want 00", io_resp_valid); end
        vectors++; if (io_init_done !== 1'b0) begin miscompares++; $display("FAIL mid_init_done got %b want 0", io_init_done); end
        reset = 1'b1;
`ifdef MEM_ARB_INIT_SWEEP_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if ({io_mem_wrEna, io_mem_wrAddr, io_req_ready} !== {1'b1, 2'(i), 2'b00}) begin miscompares++; $display("FAIL mid_sweep[%0d] got %b/%0d/%b want 1/%0d/00", i, io_mem_wrEna, io_mem_wrAddr, io_req_ready, i); end
            tick();
        end
        for (int i = 0; i < 4; i++) exp_mem[i] = 2'd0;
`endif
        #1;
        vectors++; if (io_init_done !== 1'b1) begin miscompares++; $display("FAIL mid_done_after got %b want 1", io_init_done); end
        vectors++; if (io_req_ready !== 2'b01) begin miscompares++; $display("FAIL mid_ptr_ready got %b want 01", io_req_ready); end
        tick();
        vectors++; if ({io_resp_valid, io_resp_data} !== {2'b01, exp_mem[2]}) begin miscompares++; $display("FAIL mid_resp got %b/%0d want 01/%0d", io_resp_valid, io_resp_data, exp_mem[2]); end
        set_req(2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 4; i++) begin
            mem[i]     = 2'd0;
            exp_mem[i] = 2'd0;
        end
        reset = 1'b0;
        set_req(2'b00, 2'b00, 2'd0, 2'd0, 2'd0, 2'd0);
        #1;
        test_reset();
`ifdef MEM_ARB_INIT_SWEEP_EN
        test_init_sweep();
`else
        test_first_cycle();
`endif
        test_write_read();
        test_back_to_back();
        test_lone_and_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
